// File: rtl/imm_instr_encoder_if.sv
// Field-bundle input, encoded-word output and address-load controls of the
// immediate instruction encoder, bundled for connection as one port.
interface imm_instr_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_type;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [7:0]        err_count;
  logic              addr_set;
  logic [ADDR_W-1:0] addr_set_val;

  // Producer of field bundles / consumer of encoded words.
  modport master (
    output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, out_ready, addr_set, addr_set_val,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, out_ready, addr_set, addr_set_val,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/imm_instr_encoder.sv
// RV32I instruction assembler: registers decoded fields plus immediate legality,
// then packs the word and streams it with an auto-incrementing byte address.
module imm_instr_encoder #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic            CPU_CLK,
  input logic            CPU_RST,
  imm_instr_encoder_if.slave bus
);

  localparam logic [2:0]  T_NOIMM = 3'd0;
  localparam logic [2:0]  T_ITYPE = 3'd1;
  localparam logic [2:0]  T_STYPE = 3'd2;
  localparam logic [2:0]  T_BTYPE = 3'd3;
  localparam logic [2:0]  T_UTYPE = 3'd4;
  localparam logic [2:0]  T_JTYPE = 3'd5;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        legal;
  } s1_t;

  // vld_q[0] = stage-1 holds a bundle, vld_q[1] = stage-2 holds a word.
  logic [1:0]        vld_q, vld_d;
  s1_t               s1_q, s1_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        errcnt_q, errcnt_d;

  logic        out_fire, s2_free, s1_move, in_rdy, in_fire, legal;
  logic [31:0] packed_w;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr_set_val[1:0];

  // Ready is built from registered state and out_ready only.
  always_comb begin
    out_fire = vld_q[1] & bus.out_ready;
    s2_free  = ~vld_q[1] | bus.out_ready;
    s1_move  = vld_q[0] & s2_free;
    in_rdy   = ~vld_q[0] | s2_free;
    in_fire  = bus.in_valid & in_rdy;
  end

  // Immediate must sign-extend from the field's top bit; B/J targets are 2-byte aligned.
  always_comb begin
    legal = 1'b0;
    case (bus.in_type)
      T_NOIMM:          legal = 1'b1;
      T_ITYPE, T_STYPE: legal = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
      T_BTYPE:          legal = ((&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]))
                                & ~bus.in_imm[0];
      T_UTYPE:          legal = ~(|bus.in_imm[11:0]);
      T_JTYPE:          legal = ((&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]))
                                & ~bus.in_imm[0];
      default:          legal = 1'b0;
    endcase
  end

  always_comb begin
    packed_w = NOP;
    case (s1_q.typ)
      T_NOIMM: packed_w = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
      T_ITYPE: packed_w = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
      T_STYPE: packed_w = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3,
                           s1_q.imm[4:0], s1_q.op};
      T_BTYPE: packed_w = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                           s1_q.f3, s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
      T_UTYPE: packed_w = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
      T_JTYPE: packed_w = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                           s1_q.imm[19:12], s1_q.rd, s1_q.op};
      default: packed_w = NOP;
    endcase
    if (!s1_q.legal) packed_w = NOP;
  end

  always_comb begin
    vld_d    = vld_q;
    s1_d     = s1_q;
    instr_d  = instr_q;
    err_d    = err_q;
    addr_d   = addr_q;
    errcnt_d = errcnt_q;

    vld_d[0] = in_fire | (vld_q[0] & ~s1_move);
    vld_d[1] = s1_move | (vld_q[1] & ~out_fire);

    if (in_fire) begin
      s1_d = '{typ: bus.in_type, op: bus.in_opcode, rd: bus.in_rd,
               rs1: bus.in_rs1, rs2: bus.in_rs2, f3: bus.in_funct3,
               f7: bus.in_funct7, imm: bus.in_imm, legal: legal};
    end

    // Output word only changes when stage 2 is loaded, so stalls hold it stable.
    if (s1_move) begin
      instr_d = packed_w;
      err_d   = ~s1_q.legal;
    end

    // A load wins over the increment; the word handshaken now keeps the old address.
    if (bus.addr_set)  addr_d = {bus.addr_set_val[ADDR_W-1:2], 2'b00};
    else if (out_fire) addr_d = addr_q + ADDR_W'(4);

    if (out_fire && err_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      vld_q    <= '0;
      s1_q     <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
      addr_q   <= BASE_ADDR;
      errcnt_q <= '0;
    end else begin
      vld_q    <= vld_d;
      s1_q     <= s1_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q[1];
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_err   = err_q;
  assign bus.err_count = errcnt_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder: directed scenarios plus a randomized stream
// scored against a range-based reference encoder.
module tb_imm_instr_encoder;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  imm_instr_encoder_if #(.ADDR_W(12)) bus ();

  imm_instr_encoder #(.ADDR_W(12), .BASE_ADDR(12'h000)) dut (
    .CPU_CLK (clk),
    .CPU_RST (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bnd_t;

  typedef struct {
    logic [31:0] ins;
    logic [11:0] ad;
    logic        er;
  } out_t;

  bnd_t drv_q[$];
  out_t got_q[$];

  function automatic bnd_t mk(logic [2:0] t, logic [6:0] op, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                              logic [31:0] imm);
    bnd_t b;
    b.t = t; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    b.f3 = f3; b.f7 = 7'h00; b.imm = imm;
    return b;
  endfunction

  // Reference: legality from signed value ranges, word built by shifting fields into place.
  function automatic logic [32:0] ref_enc(bnd_t b);
    longint      s;
    bit          ok;
    logic [31:0] w;
    logic [31:0] base;
    s    = longint'($signed(b.imm));
    base = (32'(b.rs1) << 15) | (32'(b.f3) << 12) | 32'(b.op);
    ok   = 1'b0;
    w    = 32'h0;
    case (b.t)
      3'd0: begin
        ok = 1'b1;
        w  = base | (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rd) << 7);
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = base | ((b.imm & 32'hFFF) << 20) | (32'(b.rd) << 7);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = base | (((b.imm >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20)
                  | ((b.imm & 32'h1F) << 7);
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        w  = base | (((b.imm >> 12) & 32'h1) << 31) | (((b.imm >> 5) & 32'h3F) << 25)
                  | (32'(b.rs2) << 20) | (((b.imm >> 1) & 32'hF) << 8)
                  | (((b.imm >> 11) & 32'h1) << 7);
      end
      3'd4: begin
        ok = (b.imm % 32'd4096) == 32'd0;
        w  = (b.imm & 32'hFFFFF000) | (32'(b.rd) << 7) | 32'(b.op);
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
        w  = (((b.imm >> 20) & 32'h1) << 31) | (((b.imm >> 1) & 32'h3FF) << 21)
           | (((b.imm >> 11) & 32'h1) << 20) | (((b.imm >> 12) & 32'hFF) << 12)
           | (32'(b.rd) << 7) | 32'(b.op);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  function automatic bnd_t rnd_bnd();
    bnd_t        b;
    logic [31:0] r;
    logic [31:0] edges [9];
    edges = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096,
              32'd1048574, -32'sd1048576, 32'd1048576};
    b.t   = 3'($urandom_range(0, 7));
    b.op  = 7'($urandom);
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom);
    b.f7  = 7'($urandom);
    r     = $urandom;
    case ($urandom_range(0, 5))
      0:       b.imm = r;
      1:       b.imm = {{20{r[11]}}, r[11:0]};
      2:       b.imm = {{19{r[12]}}, r[12:1], 1'b0};
      3:       b.imm = {{11{r[20]}}, r[20:1], 1'b0};
      4:       b.imm = {r[31:12], 12'h000};
      default: b.imm = edges[$urandom_range(0, 8)];
    endcase
    return b;
  endfunction

  task automatic drive(input bnd_t b);
    bus.in_valid  = 1'b1;
    bus.in_type   = b.t;
    bus.in_opcode = b.op;
    bus.in_rd     = b.rd;
    bus.in_rs1    = b.rs1;
    bus.in_rs2    = b.rs2;
    bus.in_funct3 = b.f3;
    bus.in_funct7 = b.f7;
    bus.in_imm    = b.imm;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.addr_set     = 1'b0;
    bus.addr_set_val = 12'h0;
    drive(mk(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0));
    bus.in_valid     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams drv_q with out_ready high, collecting emitted words into got_q.
  task automatic run_stream(input int budget, output bit to);
    int   i;
    int   n;
    out_t o;
    i = 0;
    n = drv_q.size();
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      if (i < n) drive(drv_q[i]);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) i++;
      if (bus.out_valid && bus.out_ready) begin
        o.ins = bus.out_instr; o.ad = bus.out_addr; o.er = bus.out_err;
        got_q.push_back(o);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    to = (got_q.size() != n);
    drv_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got=%h exp=00000000", bus.out_instr); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
    n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count got=%0d exp=0", bus.err_count); end
    n_cmp++; if (bus.out_addr !== 12'h000) begin n_bad++; $display("FAIL reset_out_addr got=%h exp=000", bus.out_addr); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_itype_latency();
    int          acc_c;
    int          v_c;
    logic [31:0] ins;
    logic [11:0] ad;
    logic        er;
    acc_c = -1; v_c = -1; ins = '0; ad = '0; er = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5));
      else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready && acc_c < 0) acc_c = c;
      if (bus.out_valid && v_c < 0) begin
        v_c = c; ins = bus.out_instr; ad = bus.out_addr; er = bus.out_err;
      end
      @(negedge clk);
    end
    n_cmp++; if (acc_c != 0) begin n_bad++; $display("FAIL itype_accept_cycle got=%0d exp=0", acc_c); end
    n_cmp++; if (v_c != 2) begin n_bad++; $display("FAIL itype_latency got=%0d exp=2", v_c); end
    n_cmp++; if (ins !== 32'h00500093) begin n_bad++; $display("FAIL itype_instr got=%h exp=00500093", ins); end
    n_cmp++; if (ad !== 12'h000) begin n_bad++; $display("FAIL itype_addr got=%h exp=000", ad); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL itype_err got=%b exp=0", er); end
  endtask

  task automatic test_bu_j_seq();
    bit          to;
    logic [31:0] e_ins [3];
    e_ins = '{32'hFE208CE3, 32'h123452B7, 32'h001000EF};
    do_reset();
    drv_q.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFF8));
    drv_q.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000));
    drv_q.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800));
    run_stream(30, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL seq_count got=%0d exp=3", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 3; k++) begin
      n_cmp++; if (got_q[k].ins !== e_ins[k]) begin n_bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, got_q[k].ins, e_ins[k]); end
      n_cmp++; if (got_q[k].ad !== 12'(4 * k)) begin n_bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, got_q[k].ad, 12'(4 * k)); end
      n_cmp++; if (got_q[k].er !== 1'b0) begin n_bad++; $display("FAIL seq_err[%0d] got=%b exp=0", k, got_q[k].er); end
    end
  endtask

  task automatic test_errors();
    bit to;
    drv_q.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048));
    drv_q.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3));
    drv_q.push_back(mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0));
    run_stream(30, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL err_count_words got=%0d exp=3", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 3; k++) begin
      n_cmp++; if (got_q[k].ins !== 32'h13) begin n_bad++; $display("FAIL err_instr[%0d] got=%h exp=00000013", k, got_q[k].ins); end
      n_cmp++; if (got_q[k].er !== 1'b1) begin n_bad++; $display("FAIL err_flag[%0d] got=%b exp=1", k, got_q[k].er); end
      n_cmp++; if (got_q[k].ad !== 12'(12 + 4 * k)) begin n_bad++; $display("FAIL err_addr[%0d] got=%h exp=%h", k, got_q[k].ad, 12'(12 + 4 * k)); end
    end
    n_cmp++; if (bus.err_count !== 8'd3) begin n_bad++; $display("FAIL err_counter got=%0d exp=3", bus.err_count); end
  endtask

  task automatic test_backpressure();
    bnd_t        bs [4];
    int          ptr;
    logic        seen;
    logic [31:0] h_ins;
    logic [11:0] h_ad;
    logic [32:0] e;
    out_t        o;
    ptr = 0; seen = 1'b0; h_ins = '0; h_ad = '0;
    for (int k = 0; k < 4; k++) bs[k] = mk(3'd1, 7'h13, 5'(k + 3), 5'(k), 5'd0, 3'd0, 32'(k * 7));
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ptr < 4) drive(bs[ptr]); else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) ptr++;
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1; h_ins = bus.out_instr; h_ad = bus.out_addr;
        end else begin
          n_cmp++; if (bus.out_instr !== h_ins || bus.out_addr !== h_ad) begin
            n_bad++; $display("FAIL bp_stable got=%h@%h exp=%h@%h", bus.out_instr, bus.out_addr, h_ins, h_ad);
          end
        end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (ptr != 2) begin n_bad++; $display("FAIL bp_accepts got=%0d exp=2", ptr); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
      if (ptr < 4) drive(bs[ptr]); else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) ptr++;
      if (bus.out_valid) begin
        o.ins = bus.out_instr; o.ad = bus.out_addr; o.er = bus.out_err;
        got_q.push_back(o);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL bp_words got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      e = ref_enc(bs[k]);
      n_cmp++; if (got_q[k].ins !== e[31:0]) begin n_bad++; $display("FAIL bp_instr[%0d] got=%h exp=%h", k, got_q[k].ins, e[31:0]); end
      n_cmp++; if (got_q[k].ad !== 12'(24 + 4 * k)) begin n_bad++; $display("FAIL bp_addr[%0d] got=%h exp=%h", k, got_q[k].ad, 12'(24 + 4 * k)); end
    end
  endtask

  task automatic test_addr_set();
    bnd_t a;
    bnd_t b;
    logic [32:0] ea;
    logic [32:0] eb;
    a = mk(3'd1, 7'h13, 5'd7, 5'd2, 5'd0, 3'd0, 32'd100);
    b = mk(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFFFFF0);
    ea = ref_enc(a); eb = ref_enc(b);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    bus.addr_set = 1'b1; bus.addr_set_val = 12'h010;
    @(negedge clk);
    bus.addr_set = 1'b0;
    drive(a);
    #1;
    n_cmp++; if (bus.out_addr !== 12'h010) begin n_bad++; $display("FAIL aset_load got=%h exp=010", bus.out_addr); end
    @(negedge clk);
    drive(b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1; bus.addr_set = 1'b1; bus.addr_set_val = 12'h103;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ea[31:0]) begin n_bad++; $display("FAIL aset_word0 got=%b/%h exp=1/%h", bus.out_valid, bus.out_instr, ea[31:0]); end
    n_cmp++; if (bus.out_addr !== 12'h010) begin n_bad++; $display("FAIL aset_addr0 got=%h exp=010", bus.out_addr); end
    @(negedge clk);
    bus.addr_set = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== eb[31:0]) begin n_bad++; $display("FAIL aset_word1 got=%b/%h exp=1/%h", bus.out_valid, bus.out_instr, eb[31:0]); end
    n_cmp++; if (bus.out_addr !== 12'h100) begin n_bad++; $display("FAIL aset_addr1 got=%h exp=100", bus.out_addr); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit to;
    bus.addr_set = 1'b1; bus.addr_set_val = 12'hFFC; bus.in_valid = 1'b0;
    @(negedge clk);
    bus.addr_set = 1'b0;
    drv_q.push_back(mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0));
    drv_q.push_back(mk(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 32'h0));
    run_stream(20, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL wrap_words got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_cmp++; if (got_q[0].ad !== 12'hFFC) begin n_bad++; $display("FAIL wrap_addr0 got=%h exp=ffc", got_q[0].ad); end
      n_cmp++; if (got_q[1].ad !== 12'h000) begin n_bad++; $display("FAIL wrap_addr1 got=%h exp=000", got_q[1].ad); end
    end
  endtask

  task automatic test_err_saturate();
    bit to;
    for (int k = 0; k < 260; k++) drv_q.push_back(mk(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'($urandom)));
    run_stream(400, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL sat_words got=%0d exp=260", got_q.size()); end
    n_cmp++; if (bus.err_count !== 8'd255) begin n_bad++; $display("FAIL sat_err_count got=%0d exp=255", bus.err_count); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    drive(mk(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 32'd1));
    @(negedge clk);
    drive(mk(3'd1, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 32'd2));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_addr !== 12'h000) begin n_bad++; $display("FAIL mrst_out_addr got=%h exp=000", bus.out_addr); end
    n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL mrst_err_count got=%0d exp=0", bus.err_count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_ghost_word cycle=%0d got=%b exp=0", c, bus.out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [11:0] m_addr;
    int          m_err;
    bnd_t        b;
    logic        stall;
    logic        st_set;
    logic [31:0] st_ins;
    logic [11:0] st_ad;
    logic        st_er;
    logic        fire;
    do_reset();
    m_addr = 12'h000; m_err = 0; stall = 1'b0;
    st_set = 1'b0; st_ins = '0; st_ad = '0; st_er = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      b = rnd_bnd();
      if (c < 2900 && $urandom_range(0, 3) != 0) drive(b);
      else bus.in_valid = 1'b0;
      bus.out_ready    = (c >= 2900) || ($urandom_range(0, 3) != 0);
      bus.addr_set     = (c < 2900) && ($urandom_range(0, 60) == 0);
      bus.addr_set_val = 12'($urandom);
      #1;
      if (stall) begin
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== st_ins || bus.out_err !== st_er) begin
          n_bad++; $display("FAIL rnd_stall_hold got=%b/%h/%b exp=1/%h/%b", bus.out_valid, bus.out_instr, bus.out_err, st_ins, st_er);
        end
        if (!st_set) begin
          n_cmp++; if (bus.out_addr !== st_ad) begin n_bad++; $display("FAIL rnd_stall_addr got=%h exp=%h", bus.out_addr, st_ad); end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_enc(b));
      fire = bus.out_valid && bus.out_ready;
      if (fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra_word got=%h exp=none", bus.out_instr);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_instr !== e[31:0] || bus.out_err !== e[32]) begin
            n_bad++; $display("FAIL rnd_word got=%h/%b exp=%h/%b", bus.out_instr, bus.out_err, e[31:0], e[32]);
          end
          n_cmp++; if (bus.out_addr !== m_addr) begin n_bad++; $display("FAIL rnd_addr got=%h exp=%h", bus.out_addr, m_addr); end
          n_cmp++; if (bus.err_count !== 8'(m_err)) begin n_bad++; $display("FAIL rnd_err_count got=%0d exp=%0d", bus.err_count, m_err); end
          if (e[32] && m_err < 255) m_err++;
        end
      end
      stall  = bus.out_valid && !bus.out_ready;
      st_set = bus.addr_set;
      st_ins = bus.out_instr; st_ad = bus.out_addr; st_er = bus.out_err;
      if (bus.addr_set) m_addr = {bus.addr_set_val[11:2], 2'b00};
      else if (fire)    m_addr = m_addr + 12'd4;
      @(negedge clk);
    end
    bus.addr_set = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_lost_words got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_itype_latency();
    test_bu_j_seq();
    test_errors();
    test_backpressure();
    test_addr_set();
    test_wrap();
    test_err_saturate();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the pipeline's immediate-generation path: assembles a 32-bit RV32I instruction word from decoded fields and a 32-bit signed immediate.
- Range- and alignment-checks the immediate against the instruction type.
- Streams encoded words with auto-incrementing word addresses to the instruction-memory loader / debug patch port.
- Two-stage valid/ready pipeline with backpressure.

Parameters:
ADDR_W, 12, width of out_addr (byte address).
BASE_ADDR, 0, out_addr value after reset; must be word-aligned.

Ports:
CPU_CLK  input  1  clock, rising edge
CPU_RST  input  1  synchronous active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder accepts bundle this cycle
in_type  input  3  immediate type (Parameters.v codes NOIMM, ITYPE, STYPE, BTYPE, UTYPE, JTYPE)
in_opcode  input  7  opcode[6:0]
in_rd  input  5  rd
in_rs1  input  5  rs1
in_rs2  input  5  rs2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (NOIMM only)
in_imm  input  32  signed immediate, full byte-offset value
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_instr
out_err  output  1  word was illegal and replaced by NOP
err_count  output  8  saturating count of emitted error words
addr_set  input  1  load address counter
addr_set_val  input  ADDR_W  new address; bits[1:0] forced to 0

Behaviour:
- Reset state: both stage valid bits 0, out_valid=0, out_instr=0, out_err=0, err_count=0, out_addr=BASE_ADDR. Reset mid-stream discards all in-flight words.
- Handshakes:
  - Accept on in_valid&in_ready; emit on out_valid&out_ready.
  - in_ready = !s1_valid | s1 moving to s2; s1 moves when !s2_valid | (out_valid&out_ready).
  - in_ready depends only on registered state and out_ready; no combinational path from in_valid.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput 1 word/cycle. Holds 2 words maximum. Output order equals input order.
- Stage 1 registers fields and computes legality:
  - NOIMM: always legal; imm ignored.
  - ITYPE, STYPE: in_imm[31:11] all equal.
  - BTYPE: in_imm[31:12] all equal and in_imm[0]==0.
  - JTYPE: in_imm[31:20] all equal and in_imm[0]==0.
  - UTYPE: in_imm[11:0]==0.
  - Codes 6, 7: illegal.
- Stage 2 packs the word:
  - NOIMM: {f7, rs2, rs1, f3, rd, op}
  - ITYPE: {imm[11:0], rs1, f3, rd, op}
  - STYPE: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - BTYPE: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - UTYPE: {imm[31:12], rd, op}
  - JTYPE: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - Illegal: out_instr=32'h00000013, out_err=1.
- Stall: while out_valid & !out_ready, out_instr/out_addr/out_err stay stable.
- err_count: increments on each emitted word with out_err=1; saturates at 255.
- Address counter:
  - out_addr increments by 4 on each output handshake; wraps modulo 2^ADDR_W.
  - addr_set has priority over a simultaneous handshake: the handshaken word uses the old address, and the next word uses {addr_set_val[ADDR_W-1:2], 2'b00}.
- Unused fields per type are ignored: no X propagation, no legality effect.

Test Plan:
- ITYPE, op=0x13, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> out_instr=0x00500093, out_addr=0x000, out_err=0, out_valid exactly 2 cycles after accept.
- BTYPE, op=0x63, rs1=1, rs2=2, f3=0, imm=0xFFFFFFF8 -> 0xFE208CE3; then UTYPE, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7 at out_addr=0x004; then JTYPE, op=0x6F, rd=1, imm=0x800 -> 0x001000EF at 0x008.
- Errors: ITYPE imm=2048, then BTYPE imm=3, then type=7 -> three outputs 0x00000013 with out_err=1, err_count=3, addresses still advance by 4.
- Backpressure: hold out_ready=0 and stream 4 bundles -> in_ready drops after 2 accepts; outputs stay stable; after out_ready=1, all 4 words emerge in order with consecutive addresses and no loss or duplication.
- addr_set=1, addr_set_val=0x103, asserted in the same cycle as an output handshake at 0x010 -> that word reports 0x010, next word reports 0x100. Separately, run the counter from 0xFFC: next address wraps to 0x000.
- Assert CPU_RST with 2 words in flight -> next cycle out_valid=0, out_addr=BASE_ADDR, err_count=0, in_ready=1; the held words are never emitted.
